muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer and HI/LO register owner for the pipelined MIPS32 core. It accepts MULT/MULTU/DIV/DIVU requests from the Execute stage and runs a 32-iteration shift-add multiply or restoring divide. It writes the 64-bit result into HI/LO and returns MFHI/MFLO data. While an operation is in flight it raises a stall toward the hazard unit, so dependent HI/LO reads and back-to-back mul/div instructions hold in Execute.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1  single core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  qualified mul/div enable from Execute; sampled only in IDLE.
- `div_sel`  in  1  0 = multiply, 1 = divide.
- `signed_op`  in  1  1 = MULT/DIV, 0 = MULTU/DIVU.
- `op_a`  in  WIDTH  rs operand (multiplicand / dividend).
- `op_b`  in  WIDTH  rt operand (multiplier / divisor).
- `hilo_rd`  in  1  MFHI/MFLO present in Execute.
- `hi_lo_sel`  in  1  0 = HI, 1 = LO.
- `hilo_out`  out  WIDTH  selected HI or LO, combinational from the registers.
- `busy`  out  1  state is not IDLE.
- `stall`  out  1  request to freeze F/D/E and bubble Memory.
- `done`  out  1  one-cycle pulse after HI/LO are written.
- `div_zero`  out  1  sticky flag: the last divide had `op_b == 0`.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start=1` latches the operands and op type.
  - For signed operations it takes absolute values and records the result signs:
    - product sign = sign(a) XOR sign(b);
    - quotient sign = sign(a) XOR sign(b);
    - remainder sign = sign(a).
  - Loads the 6-bit iteration counter with 32 and moves to RUN.
- RUN, one iteration per cycle:
  - Multiply: 64-bit accumulator; conditional add of multiplicand, then shift right.
  - Divide: restoring; shift the remainder left, trial subtract the divisor, set the quotient bit.
  - The counter decrements each cycle; at 0 the state moves to FIX.
- FIX:
  - Applies two's-complement negation where the recorded sign requires it.
  - Writes HI/LO:
    - multiply: HI = upper product, LO = lower product;
    - divide: HI = remainder, LO = quotient.
  - Goes to IDLE.
- Divide by zero: HI = `op_a` (raw), LO = all ones, sign fix skipped, `div_zero` = 1, full latency still taken.
- Any divide with nonzero divisor clears `div_zero`. Multiplies leave it unchanged.
- Signed −2^31 / −1: LO = 0x80000000, HI = 0. No trap.
- `stall = busy & (hilo_rd | start)`. An independent instruction in Execute proceeds while the unit runs.
- `start` while busy is ignored; the stall keeps the instruction in Execute until IDLE.
- `hilo_rd` and `start` are never both 1; if they are, `start` has priority and `hilo_out` shows the pre-operation value.
- Reset (`rst=0`) at any time:
  - state = IDLE; HI, LO, and counter = 0;
  - `busy`, `stall`, `done`, and `div_zero` = 0;
  - any in-flight operation is discarded.

## Timing
- Edge E0 samples `start` and enters RUN.
- Edges E1–E32 perform the iterations.
- Edge E33 (FIX) writes HI/LO and enters IDLE.
- `done` = 1 during the cycle after E33; new HI/LO are visible on `hilo_out` in that same cycle.
- `busy` = 1 from after E0 through E33: 33 cycles.
- A new `start` is accepted at E34 at the earliest, giving 34 cycles of issue-to-issue throughput.
- `hilo_out` is a pure mux of the registers, with no pipeline delay.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined:
  - the divider datapath and divide-by-zero logic are compiled in;
  - `div_zero` is functional.
- Undefined:
  - the divider logic is removed;
  - `start` with `div_sel=1` completes as a no-op with the same 34-cycle timing;
  - HI/LO are unchanged, `done` still pulses, and `div_zero` is tied to 0.
- The multiply path is identical in both builds.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` in the cycle after E33; `busy` high for exactly 33 cycles.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 → HI = 0x1234, LO = 0xFFFFFFFF, `div_zero` = 1. A following DIVU 9 / 3 clears it and gives LO = 3.
- MULT issued, then `hilo_rd=1` (LO) one cycle later:
  - `stall` = 1 until E33;
  - the cycle after, `hilo_out` = the new LO and `stall` = 0;
  - a second `start` during busy is stalled, not accepted, and runs after.
- Reset:
  - `rst` asserted at RUN iteration 10 → immediately `busy` = 0 and HI = LO = 0; no `done` pulse.
  - With `MULDIV_DIV_EN` undefined, DIVU 10 / 2 leaves HI/LO unchanged and `done` still pulses after 34 cycles.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-step multiply/divide sequencer that owns the HI/LO registers.
//
// Build option: define MULDIV_DIV_EN to compile in the restoring divider and the
// divide-by-zero flag. Without it, a divide request runs the same 34-cycle
// sequence, leaves HI/LO untouched, still pulses done, and div_zero stays 0.
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-low reset
//   start      mul/div request, sampled only while idle
//   div_sel    0 = multiply, 1 = divide
//   signed_op  1 = MULT/DIV, 0 = MULTU/DIVU
//   op_a       multiplicand / dividend
//   op_b       multiplier / divisor
//   hilo_rd    MFHI/MFLO present in Execute
//   hi_lo_sel  0 = HI, 1 = LO
//   hilo_out   selected HI or LO, straight from the registers
//   busy       sequencer not idle
//   stall      hold F/D/E while a dependent instruction waits
//   done       one-cycle pulse after HI/LO are written
//   div_zero   sticky: the last divide had a zero divisor
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_sel,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hilo_rd,
    input  logic             hi_lo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_zero
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic             div_q, div_d, neg_q, neg_d, done_q, done_d;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_nxt;

    assign abs_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply: acc = {partial product, multiplier}; add on the multiplier LSB, then shift right
    // keeping the carry as the new top bit.
    assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic             rneg_q, rneg_d, dz_q, dz_d, divz_q, divz_d;
    logic [WIDTH:0]   div_sh, div_df;
    logic [W2-1:0]    div_nxt;

    // Divide: acc = {remainder, dividend/quotient}; the dividend shifts out of the low half
    // while quotient bits shift in. A borrow in div_df means the trial subtract failed.
    assign div_sh  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign div_df  = div_sh - {1'b0, m_q};
    assign div_nxt = div_df[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {div_df[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign div_zero = divz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign hilo_out = hi_lo_sel ? lo_q : hi_q;
    assign busy     = state_q != IDLE;
    assign stall    = busy & (hilo_rd | start);
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        div_d   = div_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIV_EN
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        divz_d  = divz_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = 6'(WIDTH);
                div_d   = div_sel;
                neg_d   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                acc_d   = {{WIDTH{1'b0}}, div_sel ? abs_a : abs_b};
                m_d     = div_sel ? abs_b : abs_a;
`ifdef MULDIV_DIV_EN
                rneg_d  = signed_op & op_a[WIDTH-1];
                dz_d    = op_b == '0;
`endif
            end
            RUN: begin
`ifdef MULDIV_DIV_EN
                acc_d   = div_q ? div_nxt : mul_nxt;
`else
                acc_d   = mul_nxt;
`endif
                cnt_d   = cnt_q - 6'd1;
                state_d = (cnt_q == 6'd1) ? FIX : RUN;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!div_q) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
`ifdef MULDIV_DIV_EN
                else begin
                    // A zero divisor leaves the remainder equal to |op_a|; the remainder
                    // sign fix restores the raw op_a, and the quotient stays all ones.
                    hi_d   = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
                    lo_d   = (neg_q && !dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    divz_d = dz_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
`ifdef MULDIV_DIV_EN
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            divz_q  <= divz_d;
`endif
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, div_sel = 1'b0, signed_op = 1'b0;
    logic [31:0] op_a = '0, op_b = '0;
    logic        hilo_rd = 1'b0, hi_lo_sel = 1'b1;
    logic [31:0] hilo_out;
    logic        busy, stall, done, div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          e0;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;
    int          checks = 0, errors = 0, cyc = 0, busy_cnt = 0, done_cnt = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .div_sel(div_sel), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .hilo_rd(hilo_rd), .hi_lo_sel(hi_lo_sel),
        .hilo_out(hilo_out), .busy(busy), .stall(stall), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with native wide arithmetic.
    function automatic exp_t model(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b, input int e0);
        exp_t   e;
        longint sa, sb;
        int     ia, ib;
        if (!d) begin
            sa = s ? longint'($signed(a)) : longint'({32'b0, a});
            sb = s ? longint'($signed(b)) : longint'({32'b0, b});
            {m_hi, m_lo} = 64'(sa * sb);
        end else begin
`ifdef MULDIV_DIV_EN
            ia = a;
            ib = b;
            if (b == 0) begin
                m_hi = a;
                m_lo = '1;
                m_dz = 1'b1;
            end else begin
                m_dz = 1'b0;
                if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = 0;
                end else if (s) begin
                    m_lo = 32'(ia / ib);
                    m_hi = 32'(ia % ib);
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
`else
            ia = 0;
            ib = 0;
`endif
        end
        e.hi = m_hi;
        e.lo = m_lo;
        e.dz = m_dz;
        e.e0 = e0;
        return e;
    endfunction

    task automatic drive(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
        div_sel = d;
        signed_op = s;
        op_a = a;
        op_b = b;
    endtask

    task automatic issue(input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("issue_wait_timeout", 1, 0);
        drive(d, s, a, b);
        start = 1'b1;
        q.push_back(model(d, s, a, b, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Monitor: on every done pulse pop the oldest expectation and compare.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            busy_cnt = 0;
            continue;
        end
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("lo", hilo_out, e.lo);
                hi_lo_sel = 1'b0;
                #1 chk("hi", hilo_out, e.hi);
                hi_lo_sel = 1'b1;
                chk("div_zero", div_zero, e.dz);
                chk("latency", cyc - e.e0, 33);
                chk("busy_cycles", busy_cnt, 33);
            end
            busy_cnt = 0;
        end
    end

    initial begin
        int  n, dcnt;
        bit  ok, d, s;
        logic [31:0] a, b;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_lo", hilo_out, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        issue(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(0, 1, -32'sd3, 32'd5);
        issue(0, 1, 32'h8000_0000, 32'h8000_0000);
        issue(1, 1, -32'sd7, 32'd2);
        issue(1, 0, 32'd100, 32'd7);
        issue(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1, 0, 32'h1234, 32'd0);
        issue(1, 0, 32'd9, 32'd3);

        // Dependent MFLO right behind a MULT holds until the result lands.
        issue(0, 1, 32'd1234567, -32'sd89);
        @(negedge clk);
        hilo_rd = 1'b1;
        #1;
        ok = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            if (!stall) ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_rd_held", ok, 1);
        chk("stall_rd_cycles", n, 33);
        chk("stall_rd_release", stall, 0);
        hilo_rd = 1'b0;

        // A second start while busy is stalled and accepted only once idle.
        issue(0, 0, 32'hDEAD_BEEF, 32'h0000_1003);
        @(negedge clk);
        drive(0, 1, 32'h7FFF_FFFF, 32'h8000_0001);
        start = 1'b1;
        #1;
        ok = 1'b1;
        n = 0;
        while (busy && n < 60) begin
            if (!stall) ok = 1'b0;
            n++;
            @(negedge clk);
            #1;
        end
        chk("stall_start_held", ok, 1);
        chk("stall_start_cycles", n, 33);
        q.push_back(model(0, 1, 32'h7FFF_FFFF, 32'h8000_0001, cyc + 1));
        @(posedge clk);
        #1 start = 1'b0;
        chk("second_start_accepted", busy, 1);

        // Reset during iteration 10 discards the operation.
        issue(0, 1, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_lo", hilo_out, 0);
        chk("midrst_div_zero", div_zero, 0);
        q.delete();
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        dcnt = done_cnt;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_cnt, dcnt);

        issue(0, 0, 32'h0001_0001, 32'h0003_0007);
        issue(1, 0, 32'd10, 32'd2);

        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'h8000_0000; b = '1; end
                3: a = $urandom_range(0, 1000);
                default: ;
            endcase
            issue(d, s, a, b);
        end

        n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
